fifo_burst_reader: RTL and testbench
====================================

// Module: fifo_burst_reader
// PURPOSE
//  Read-side master for the single-port-RAM FIFO (Fifo_Sig_Ram). The FIFO is show-ahead: data valid while !empty, rden pops.
//  Drains the FIFO in fixed-length bursts onto a valid/ready stream, marking each burst with sop/eop.
//  A flush request drains a final partial burst. Sits between the FIFO and the downstream packet consumer.
// PARAMETERS
//  WIDTH      8    data word width; equals FIFO WIDTH
//  DEPTH      128  FIFO depth; sets fifo_cnt width
//  BURST_LEN  16   words per full burst; legal range 1..DEPTH, elaboration $error otherwise
// PORTS
//  clk        in   1                  single clock, rising edge
//  rst_n      in   1                  asynchronous active-low reset
//  fifo_rden  out  1                  pop request to FIFO (rden)
//  fifo_data  in   WIDTH              FIFO head word (data_out)
//  fifo_empty in   1                  FIFO empty
//  fifo_cnt   in   $clog2(DEPTH)+1    FIFO occupancy (data_cnt)
//  flush      in   1                  level; allow a partial burst of whatever is stored
//  m_valid    out  1                  stream word valid
//  m_ready    in   1                  stream accept
//  m_data     out  WIDTH              stream word
//  m_sop      out  1                  first word of burst, qualified by m_valid
//  m_eop      out  1                  last word of burst, qualified by m_valid
//  busy       out  1                  burst in progress (state != IDLE)
//  burst_done out  1                  1-cycle pulse when eop word is accepted
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, remain=0. Reset mid-burst abandons the burst; words already popped are lost. No eop is emitted.
//  FSM states:
//   IDLE: if fifo_cnt>=BURST_LEN, load len=BURST_LEN and go to XFER.
//         Else if flush && !fifo_empty, load len=fifo_cnt and go to XFER. This is fifo_cnt sampled this cycle, always <BURST_LEN here.
//         Full-burst check has priority over flush.
//   XFER: pop while remain>0. Go to LAST on the pop of the word with remain==1.
//   LAST: wait for the eop word handshake, then go to IDLE and pulse burst_done.
//         The next burst decision is made in IDLE on the following cycle, so there is 1 idle cycle between bursts.
//  Output stage: one register stage (m_valid/m_data/m_sop/m_eop).
//   fifo_rden = (state==XFER) && remain!=0 && !fifo_empty && (!m_valid || m_ready).
//   The combinational path m_ready->fifo_rden is intended.
//   On pop: m_data<=fifo_data, m_valid<=1, m_sop<=(remain==len), m_eop<=(remain==1), remain<=remain-1.
//   Else if m_valid && m_ready: m_valid<=0.
//  Latency: word at FIFO head in XFER appears on m_data the next cycle. Sustains 1 word/cycle with m_ready held high.
//  Stall: while m_valid && !m_ready, m_data/m_sop/m_eop hold stable and fifo_rden=0.
//  Underflow: fifo_empty during XFER stalls with no pop and no error. This is normal for the FIFO's internal read-cache refill bubbles.
//  fifo_rden is never asserted while fifo_empty=1.
//  flush deasserting mid-burst has no effect; the burst length is latched at IDLE exit.
//  remain/len width: $clog2(BURST_LEN+1) bits. No wrap; remain stops at 0.
//  BURST_LEN==1: every word has m_sop=m_eop=1.
// STRUCTURE
//  Package fifo_burst_pkg: state localparams ST_IDLE=2'd0, ST_XFER=2'd1, ST_LAST=2'd2; function clog2_safe.
//  One natural sub-module, stream_out_reg: the output register stage with load/accept.
//  The FSM and counters stay in the top module.
// TESTING (bench: Fifo_Sig_Ram WIDTH=8 DEPTH=128 -> DUT BURST_LEN=4; self-checking scoreboard)
//  1 Write 0x01..0x08, m_ready=1 -> two bursts 01-04, 05-08; sop on 01/05, eop on 04/08; 2 burst_done pulses; 1 idle cycle between bursts.
//  2 Write 0x10..0x12, flush=0 -> no fifo_rden for 50 cycles. Then flush=1 -> burst 10,11,12 with sop on 10 and eop on 12.
//  3 Write 8 words, m_ready toggled randomly -> order preserved, m_data stable under stall, no pop while m_valid&&!m_ready.
//  4 FIFO filled to 128 (full) while m_ready=0, then m_ready=1 -> 32 bursts, data 0..127 in order, FIFO ends empty.
//  5 rst_n pulsed low mid-burst after 2 words accepted -> all outputs 0 asynchronously. After release, the next burst starts with m_sop=1.
//  6 Concurrent write/read: FIFO written 1 word/2 cycles -> XFER stalls on empty with no fifo_rden, and every burst still has 4 words.

Source files
------------

// File: rtl/fifo_burst_reader_pkg.sv
// Shared state encoding and width helper for the FIFO burst reader.
package fifo_burst_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_XFER = 2'd1;
  localparam logic [1:0] ST_LAST = 2'd2;

  // Width of a counter able to hold n distinct values, never narrower than 1 bit.
  function automatic int clog2_safe(input int n);
    if (n <= 2) begin
      return 1;
    end else begin
      return $clog2(n);
    end
  endfunction

endpackage

// File: rtl/fifo_burst_reader_out.sv
// Registered valid/ready output stage: loads a word on pop, drops valid on acceptance.
module stream_out_reg #(
  parameter int WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_sop,
  input  logic             i_eop,
  input  logic             i_ready,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_data,
  output logic             o_sop,
  output logic             o_eop
);

  logic             r_valid;
  logic [WIDTH-1:0] r_data;
  logic             r_sop;
  logic             r_eop;

  // Word register; data and framing hold while stalled.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_valid <= 1'b0;
      r_data  <= {WIDTH{1'b0}};
      r_sop   <= 1'b0;
      r_eop   <= 1'b0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_data  <= i_data;
      r_sop   <= i_sop;
      r_eop   <= i_eop;
    end else if (r_valid && i_ready) begin
      r_valid <= 1'b0;
    end else begin
      r_valid <= r_valid;
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;
  assign o_sop   = r_sop;
  assign o_eop   = r_eop;

endmodule

// File: rtl/fifo_burst_reader.sv
// Drains a show-ahead FIFO in fixed-length bursts (or a flushed partial burst)
// onto a valid/ready stream framed with sop/eop.
module fifo_burst_reader
  import fifo_burst_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 128,
  parameter int BURST_LEN = 16
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  output logic                     o_fifo_rden,
  input  logic [WIDTH-1:0]         i_fifo_data,
  input  logic                     i_fifo_empty,
  input  logic [$clog2(DEPTH):0]   i_fifo_cnt,
  input  logic                     i_flush,
  output logic                     o_m_valid,
  input  logic                     i_m_ready,
  output logic [WIDTH-1:0]         o_m_data,
  output logic                     o_m_sop,
  output logic                     o_m_eop,
  output logic                     o_busy,
  output logic                     o_burst_done
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int RW = clog2_safe(BURST_LEN + 1);
  localparam logic [CW-1:0] CNT_BURST = CW'(BURST_LEN);
  localparam logic [RW-1:0] LEN_BURST = RW'(BURST_LEN);
  localparam logic [RW-1:0] ONE       = RW'(1);

  if (BURST_LEN < 1 || BURST_LEN > DEPTH) begin : gen_bad_burst_len
    $error("fifo_burst_reader: BURST_LEN must be within 1..DEPTH");
  end

  logic [1:0]    r_state;
  logic [1:0]    w_next_state;
  logic [RW-1:0] r_remain;
  logic [RW-1:0] r_len;
  logic          r_busy;
  logic          r_burst_done;
  logic          w_full_ready;
  logic          w_flush_ready;
  logic          w_pop;
  logic          w_sop;
  logic          w_eop;
  logic          w_eop_accept;

  // State register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state: a full burst wins over a flush; LAST waits for the eop handshake.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_full_ready) begin
          w_next_state = ST_XFER;
        end else if (w_flush_ready) begin
          w_next_state = ST_XFER;
        end else begin
          w_next_state = ST_IDLE;
        end
      end
      ST_XFER: begin
        if (w_pop && (r_remain == ONE)) begin
          w_next_state = ST_LAST;
        end else begin
          w_next_state = ST_XFER;
        end
      end
      ST_LAST: begin
        if (w_eop_accept) begin
          w_next_state = ST_IDLE;
        end else begin
          w_next_state = ST_LAST;
        end
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  // Pop only when the output register can take a word (m_ready feeds rden directly).
  always_comb begin
    w_full_ready  = (i_fifo_cnt >= CNT_BURST);
    w_flush_ready = i_flush && !i_fifo_empty;
    w_pop         = 1'b0;
    w_eop_accept  = 1'b0;
    case (r_state)
      ST_XFER: begin
        w_pop = (r_remain != {RW{1'b0}}) && !i_fifo_empty && (!o_m_valid || i_m_ready);
      end
      ST_LAST: begin
        w_eop_accept = o_m_valid && i_m_ready;
      end
      default: begin
        w_pop        = 1'b0;
        w_eop_accept = 1'b0;
      end
    endcase
    w_sop = (r_remain == r_len);
    w_eop = (r_remain == ONE);
  end

  // Burst length latched on IDLE exit; remain counts down per pop and stops at 0.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_remain <= {RW{1'b0}};
      r_len    <= {RW{1'b0}};
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_full_ready) begin
            r_len    <= LEN_BURST;
            r_remain <= LEN_BURST;
          end else if (w_flush_ready) begin
            r_len    <= RW'(i_fifo_cnt);
            r_remain <= RW'(i_fifo_cnt);
          end else begin
            r_remain <= r_remain;
          end
        end
        ST_XFER: begin
          if (w_pop) begin
            r_remain <= r_remain - ONE;
          end else begin
            r_remain <= r_remain;
          end
        end
        default: r_remain <= r_remain;
      endcase
    end
  end

  // Status flags: busy mirrors non-IDLE state, burst_done pulses the cycle after eop acceptance.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_busy       <= 1'b0;
      r_burst_done <= 1'b0;
    end else begin
      r_busy       <= (w_next_state != ST_IDLE);
      r_burst_done <= w_eop_accept;
    end
  end

  stream_out_reg #(
    .WIDTH (WIDTH)
  ) u_out (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_load  (w_pop),
    .i_data  (i_fifo_data),
    .i_sop   (w_sop),
    .i_eop   (w_eop),
    .i_ready (i_m_ready),
    .o_valid (o_m_valid),
    .o_data  (o_m_data),
    .o_sop   (o_m_sop),
    .o_eop   (o_m_eop)
  );

  assign o_fifo_rden  = w_pop;
  assign o_busy       = r_busy;
  assign o_burst_done = r_burst_done;

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Self-checking bench: behavioural show-ahead FIFO plus an in-order word/burst scoreboard.
module tb_fifo_burst_reader;

  localparam int WIDTH = 8;
  localparam int DEPTH = 128;
  localparam int BL    = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       rden;
  logic [7:0] fifo_data;
  logic       fifo_empty;
  logic [7:0] fifo_cnt;
  logic       flush;
  logic       m_valid;
  logic       m_ready;
  logic [7:0] m_data;
  logic       m_sop;
  logic       m_eop;
  logic       busy;
  logic       done;

  always #5 clk = ~clk;

  fifo_burst_reader #(
    .WIDTH     (WIDTH),
    .DEPTH     (DEPTH),
    .BURST_LEN (BL)
  ) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .o_fifo_rden  (rden),
    .i_fifo_data  (fifo_data),
    .i_fifo_empty (fifo_empty),
    .i_fifo_cnt   (fifo_cnt),
    .i_flush      (flush),
    .o_m_valid    (m_valid),
    .i_m_ready    (m_ready),
    .o_m_data     (m_data),
    .o_m_sop      (m_sop),
    .o_m_eop      (m_eop),
    .o_busy       (busy),
    .o_burst_done (done)
  );

  logic [7:0] fifo_q[$];
  logic [7:0] ref_q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   pos = 0;
  int   exp_len = BL;
  bit   done_exp = 1'b0;
  bit   prev_stall = 1'b0;
  logic [7:0] prev_data;
  logic prev_sop, prev_eop;
  int   n_done_obs = 0;
  int   n_acc = 0;
  int   rdy_mode = 1;
  bit   bubble = 1'b0;
  bit   no_rden = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic drive_fifo();
    fifo_empty = (fifo_q.size() == 0) || (bubble && ($urandom_range(0, 2) == 0));
    fifo_cnt   = 8'(fifo_q.size());
    fifo_data  = (fifo_q.size() != 0) ? fifo_q[0] : 8'h00;
    case (rdy_mode)
      0:       m_ready = 1'b0;
      1:       m_ready = 1'b1;
      default: m_ready = 1'($urandom_range(0, 1));
    endcase
  endtask

  // One clock: check at the falling edge, update the FIFO model, drive new inputs after the rising edge.
  task automatic cycle(input bit wr, input logic [7:0] wd);
    logic [7:0] e;
    @(negedge clk);
    check_eq("rden_while_empty", 32'(rden & fifo_empty), 32'd0);
    check_eq("rden_while_stalled", 32'(rden & m_valid & ~m_ready), 32'd0);
    if (no_rden) check_eq("rden_without_burst", 32'(rden), 32'd0);
    check_eq("burst_done", 32'(done), 32'(done_exp));
    if (done_exp) check_eq("idle_gap_busy", 32'(busy), 32'd0);
    if (done) n_done_obs++;
    if (prev_stall) begin
      check_eq("stall_valid", 32'(m_valid), 32'd1);
      check_eq("stall_data", 32'(m_data), 32'(prev_data));
      check_eq("stall_sop", 32'(m_sop), 32'(prev_sop));
      check_eq("stall_eop", 32'(m_eop), 32'(prev_eop));
    end
    done_exp = 1'b0;
    if (m_valid && m_ready) begin
      if (ref_q.size() == 0) begin
        check_eq("extra_word", 32'(m_valid & m_ready), 32'd0);
      end else begin
        e = ref_q.pop_front();
        check_eq("data", 32'(m_data), 32'(e));
        check_eq("sop", 32'(m_sop), 32'(pos == 0));
        check_eq("eop", 32'(m_eop), 32'(pos == exp_len - 1));
        n_acc++;
        if (pos == exp_len - 1) begin
          pos = 0;
          done_exp = 1'b1;
        end else begin
          pos++;
        end
      end
    end
    prev_stall = m_valid && !m_ready;
    prev_data  = m_data;
    prev_sop   = m_sop;
    prev_eop   = m_eop;
    if (rden && fifo_q.size() != 0) void'(fifo_q.pop_front());
    if (wr) begin
      fifo_q.push_back(wd);
      ref_q.push_back(wd);
    end
    @(posedge clk);
    #1;
    drive_fifo();
  endtask

  task automatic drain(input int budget);
    int k = 0;
    while ((ref_q.size() != 0 || m_valid) && k < budget) begin
      cycle(1'b0, 8'h00);
      k++;
    end
    check_eq("drain_left", 32'(ref_q.size()), 32'd0);
    repeat (3) cycle(1'b0, 8'h00);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0;
    rst_n = 1'b0;
    flush = 1'b0;
    drive_fifo();
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_valid", 32'(m_valid), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_done", 32'(done), 32'd0);
    check_eq("rst_rden", 32'(rden), 32'd0);
    rst_n = 1'b1;

    // 1: two full bursts back to back
    n0 = n_done_obs;
    for (int i = 1; i <= 8; i++) cycle(1'b1, 8'(i));
    drain(200);
    check_eq("t1_done_pulses", 32'(n_done_obs - n0), 32'd2);

    // 2: partial burst only on flush
    for (int i = 0; i < 3; i++) cycle(1'b1, 8'(8'h10 + i));
    no_rden = 1'b1;
    repeat (50) cycle(1'b0, 8'h00);
    no_rden = 1'b0;
    flush = 1'b1;
    exp_len = 3;
    drain(100);
    flush = 1'b0;
    exp_len = BL;

    // 3: random backpressure
    rdy_mode = 2;
    for (int i = 0; i < 8; i++) cycle(1'b1, 8'(8'h20 + i));
    drain(400);
    rdy_mode = 1;

    // 4: fill all 128 entries while stalled, then drain
    rdy_mode = 0;
    for (int i = 0; i < 128; i++) cycle(1'b1, 8'(i));
    rdy_mode = 1;
    n0 = n_done_obs;
    drain(2000);
    check_eq("t4_done_pulses", 32'(n_done_obs - n0), 32'd32);
    check_eq("t4_fifo_empty", 32'(fifo_cnt), 32'd0);

    // 5: reset mid-burst
    for (int i = 0; i < 4; i++) cycle(1'b1, 8'(8'hA0 + i));
    n0 = n_acc;
    for (int k = 0; k < 50 && (n_acc - n0) < 2; k++) cycle(1'b0, 8'h00);
    check_eq("t5_two_accepted", 32'((n_acc - n0) >= 2), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("t5_rst_valid", 32'(m_valid), 32'd0);
    check_eq("t5_rst_sop", 32'(m_sop), 32'd0);
    check_eq("t5_rst_eop", 32'(m_eop), 32'd0);
    check_eq("t5_rst_busy", 32'(busy), 32'd0);
    check_eq("t5_rst_done", 32'(done), 32'd0);
    fifo_q.delete();
    ref_q.delete();
    pos = 0;
    done_exp = 1'b0;
    prev_stall = 1'b0;
    drive_fifo();
    repeat (2) cycle(1'b0, 8'h00);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) cycle(1'b1, 8'(8'hB0 + i));
    drain(100);

    // 6: slow writer with read-cache bubbles on empty
    bubble = 1'b1;
    for (int i = 0; i < 8; i++) begin
      cycle(1'b1, 8'(8'hC0 + i));
      cycle(1'b0, 8'h00);
    end
    drain(300);
    bubble = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
